// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with a sticky one-hot grant held until acknowledged.
// Priority rotates past the last acknowledged requester; outputs are all registered.
module rr_arbiter_onehot #(
    parameter int NUM_REQS     = 11,
    parameter int LOG_NUM_REQS = $clog2(NUM_REQS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQS-1:0]     i__request,
    input  logic                    i__grant_ack,
    output logic                    o__grant_valid,
    output logic [NUM_REQS-1:0]     o__grant_onehot,
    output logic [LOG_NUM_REQS-1:0] o__grant_encode
);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t state_q, state_d;

    logic [LOG_NUM_REQS-1:0] ptr_q, ptr_d;
    logic [LOG_NUM_REQS-1:0] search_ptr;
    logic [LOG_NUM_REQS-1:0] masked_idx, full_idx, win_idx;
    logic [NUM_REQS-1:0]     masked_req;
    logic                    req_any;
    logic                    valid_d;
    logic [NUM_REQS-1:0]     onehot_d;
    logic [LOG_NUM_REQS-1:0] encode_d;

    // While a grant is held the search already starts past it, so an ack
    // can reload the next winner in the same edge.
    always_comb begin
        search_ptr = ptr_q;
        if (state_q == GRANTED) begin
            if (o__grant_encode == LOG_NUM_REQS'(NUM_REQS - 1))
                search_ptr = '0;
            else
                search_ptr = o__grant_encode + LOG_NUM_REQS'(1);
        end
    end

    always_comb begin
        masked_req = '0;
        masked_idx = '0;
        full_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++)
            masked_req[k] = i__request[k] && (k >= int'(search_ptr));
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (masked_req[k]) masked_idx = LOG_NUM_REQS'(k);
            if (i__request[k]) full_idx   = LOG_NUM_REQS'(k);
        end
        win_idx = (|masked_req) ? masked_idx : full_idx;
        req_any = |i__request;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = o__grant_valid;
        onehot_d = o__grant_onehot;
        encode_d = o__grant_encode;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d  = GRANTED;
                    valid_d  = 1'b1;
                    onehot_d = NUM_REQS'(1) << win_idx;
                    encode_d = win_idx;
                end
            end
            GRANTED: begin
                if (i__grant_ack) begin
                    ptr_d = search_ptr;
                    if (req_any) begin
                        onehot_d = NUM_REQS'(1) << win_idx;
                        encode_d = win_idx;
                    end else begin
                        state_d  = IDLE;
                        valid_d  = 1'b0;
                        onehot_d = '0;
                        encode_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                onehot_d = '0;
                encode_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            o__grant_valid  <= 1'b0;
            o__grant_onehot <= '0;
            o__grant_encode <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            o__grant_valid  <= valid_d;
            o__grant_onehot <= onehot_d;
            o__grant_encode <= encode_d;
        end
    end

    a_onehot0: assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0(o__grant_onehot));

    a_valid_match: assert property (
        @(posedge clk) disable iff (!rst_n)
        o__grant_valid == |o__grant_onehot);

    a_encode_match: assert property (
        @(posedge clk) disable iff (!rst_n)
        o__grant_valid |->
        o__grant_onehot == (NUM_REQS'(1) << o__grant_encode));

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Bench for rr_arbiter_onehot: directed scenarios plus random traffic
// checked against a rotating-search reference model.
module tb_rr_arbiter_onehot;

    localparam int N = 11;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         ack;
    logic         valid;
    logic [N-1:0] onehot;
    logic [W-1:0] enc;

    int n_pass  = 0;
    int n_total = 0;

    bit m_valid;
    int m_idx;
    int m_ptr;

    always #5 clk = ~clk;

    rr_arbiter_onehot #(
        .NUM_REQS(N)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i__request      (req),
        .i__grant_ack    (ack),
        .o__grant_valid  (valid),
        .o__grant_onehot (onehot),
        .o__grant_encode (enc)
    );

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    task automatic tick(input logic [N-1:0] r, input logic a);
        int w;
        req = r;
        ack = a;
        @(posedge clk);
        if (!m_valid) begin
            w = pick(m_ptr, r);
            if (w >= 0) begin
                m_valid = 1'b1;
                m_idx   = w;
            end
        end else if (a) begin
            m_ptr = (m_idx + 1) % N;
            w = pick(m_ptr, r);
            if (w >= 0) m_idx = w;
            else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_total++;
        if (valid !== 1'b0 || onehot !== 11'h000 || enc !== 4'd0)
            $display("FAIL reset_in: got %b/%h/%0d want 0/000/0", valid, onehot, enc);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(11'h000, 1'b0);
            n_total++;
            if (valid !== 1'b0 || onehot !== 11'h000 || enc !== 4'd0)
                $display("FAIL idle_c%0d: got %b/%h/%0d want 0/000/0", c, valid, onehot, enc);
            else n_pass++;
        end
        tick(11'h010, 1'b0);
        tick(11'h000, 1'b1);
        tick(11'h010, 1'b0);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h010 || enc !== 4'd4)
            $display("FAIL pre_rst: got %b/%h/%0d want 1/010/4", valid, onehot, enc);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (valid !== 1'b0 || onehot !== 11'h000 || enc !== 4'd0)
            $display("FAIL async_rst: got %b/%h/%0d want 0/000/0", valid, onehot, enc);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(11'h7FF, 1'b0);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h001 || enc !== 4'd0)
            $display("FAIL ptr_restart: got %b/%h/%0d want 1/001/0", valid, onehot, enc);
        else n_pass++;
        tick(11'h000, 1'b1);
    endtask

    task automatic test_hold_no_bubble();
        tick(11'b00000100100, 1'b0);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h004 || enc !== 4'd2)
            $display("FAIL hold_c1: got %b/%h/%0d want 1/004/2", valid, onehot, enc);
        else n_pass++;
        tick(11'b00000100100, 1'b0);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h004 || enc !== 4'd2)
            $display("FAIL hold_c2: got %b/%h/%0d want 1/004/2", valid, onehot, enc);
        else n_pass++;
        tick(11'b00000100100, 1'b1);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h020 || enc !== 4'd5)
            $display("FAIL no_bubble: got %b/%h/%0d want 1/020/5", valid, onehot, enc);
        else n_pass++;
        tick(11'h000, 1'b1);
        n_total++;
        if (valid !== 1'b0 || onehot !== 11'h000 || enc !== 4'd0)
            $display("FAIL to_idle: got %b/%h/%0d want 0/000/0", valid, onehot, enc);
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_oh;
        do_reset();
        for (int k = 0; k < 2 * N; k++) begin
            tick(11'h7FF, 1'b1);
            exp_oh = '0;
            exp_oh[k % N] = 1'b1;
            n_total++;
            if (valid !== 1'b1 || enc !== W'(k % N) || onehot !== exp_oh)
                $display("FAIL fair_g%0d: got %b/%h/%0d want 1/%h/%0d",
                         k, valid, onehot, enc, exp_oh, k % N);
            else n_pass++;
        end
        tick(11'h000, 1'b1);
    endtask

    task automatic test_wrap();
        tick(11'b10000000000, 1'b0);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h400 || enc !== 4'd10)
            $display("FAIL wrap_g10: got %b/%h/%0d want 1/400/10", valid, onehot, enc);
        else n_pass++;
        tick(11'b01000000001, 1'b1);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h001 || enc !== 4'd0)
            $display("FAIL wrap_g0: got %b/%h/%0d want 1/001/0", valid, onehot, enc);
        else n_pass++;
        tick(11'h000, 1'b1);
    endtask

    task automatic test_sticky();
        tick(11'h100, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick(11'h008, 1'b0);
            n_total++;
            if (valid !== 1'b1 || onehot !== 11'h100 || enc !== 4'd8)
                $display("FAIL sticky_c%0d: got %b/%h/%0d want 1/100/8", c, valid, onehot, enc);
            else n_pass++;
        end
        tick(11'h008, 1'b1);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h008 || enc !== 4'd3)
            $display("FAIL sticky_ack: got %b/%h/%0d want 1/008/3", valid, onehot, enc);
        else n_pass++;
        tick(11'h000, 1'b1);
    endtask

    task automatic test_idle_ack();
        for (int c = 0; c < 3; c++) begin
            tick(11'h000, 1'b1);
            n_total++;
            if (valid !== 1'b0 || onehot !== 11'h000 || enc !== 4'd0)
                $display("FAIL idle_ack_c%0d: got %b/%h/%0d want 0/000/0", c, valid, onehot, enc);
            else n_pass++;
        end
        tick(11'h080, 1'b0);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h080 || enc !== 4'd7)
            $display("FAIL req7: got %b/%h/%0d want 1/080/7", valid, onehot, enc);
        else n_pass++;
        tick(11'h000, 1'b1);
        tick(11'h000, 1'b1);
        tick(11'h7FF, 1'b0);
        n_total++;
        if (valid !== 1'b1 || onehot !== 11'h100 || enc !== 4'd8)
            $display("FAIL idle_ptr: got %b/%h/%0d want 1/100/8", valid, onehot, enc);
        else n_pass++;
        tick(11'h000, 1'b1);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] exp_oh;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = N'($urandom);
                default: r = N'($urandom) & N'($urandom);
            endcase
            tick(r, $urandom_range(0, 2) != 0);
            exp_oh = '0;
            if (m_valid) exp_oh[m_idx] = 1'b1;
            n_total++;
            if (valid !== m_valid || onehot !== exp_oh || enc !== W'(m_idx))
                $display("FAIL rand_c%0d: got %b/%h/%0d want %b/%h/%0d",
                         c, valid, onehot, enc, m_valid, exp_oh, m_idx);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_hold_no_bubble();
        test_fairness();
        test_wrap();
        test_sticky();
        test_idle_ack();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_onehot.md
Name: rr_arbiter_onehot

Overview:
- Registered round-robin arbiter that selects one of NUM_REQS requesters and holds a one-hot grant until the consumer acknowledges it.
- Sits directly upstream of the one-hot encoder stage in the router/PE crossbar control path. Its one-hot grant feeds the encoder; it also provides its own registered binary index for timing-critical consumers.
- Guarantees a legal one-hot or all-zero grant in every cycle.

Parameters:
- NUM_REQS, 11, number of requesters (2..16).
- LOG_NUM_REQS, $clog2(NUM_REQS), width of the encoded grant index.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i__request  input  NUM_REQS  per-requester request level. Bit k = requester k.
- i__grant_ack  input  1  consumer accepts the current grant this cycle.
- o__grant_valid  output  1  a grant is held.
- o__grant_onehot  output  NUM_REQS  registered one-hot grant. All-zero when not valid.
- o__grant_encode  output  LOG_NUM_REQS  registered binary index of the granted bit. 0 when not valid, never X.

Behaviour:
- Reset (rst_n low, asynchronous): o__grant_valid=0, o__grant_onehot=0, o__grant_encode=0, priority pointer ptr=0, state=IDLE. Release is synchronous to clk.
- Priority:
  - ptr (LOG_NUM_REQS bits) names the highest-priority requester.
  - Search order is ptr, ptr+1, …, NUM_REQS-1, 0, …, ptr-1.
  - The first asserted request bit in that order wins.
- State IDLE (no grant held):
  - If |i__request: register the winner into o__grant_onehot and o__grant_encode, set o__grant_valid, and go to GRANTED.
  - Latency is 1 cycle: a request sampled at edge t makes the grant visible after edge t.
  - Otherwise stay in IDLE with outputs zero.
- State GRANTED:
  - All outputs hold stable until i__grant_ack=1. The grant is sticky: it holds even if the granted request bit deasserts.
  - On ack, at the same edge:
    - ptr <= (granted index + 1) mod NUM_REQS. Wrap from NUM_REQS-1 to 0.
    - A new winner is picked from the current i__request using the updated ptr. The granted requester therefore has lowest priority.
    - If some request is asserted, load the new grant and stay in GRANTED. This gives back-to-back grants with no bubble.
    - Otherwise clear all outputs and go to IDLE.
- i__grant_ack while in IDLE is ignored: no state or ptr change.
- ptr changes only on an acked grant. Requests arriving while GRANTED never change the held grant.
- Request bits with index ≥ NUM_REQS do not exist. The winner is always < NUM_REQS, so o__grant_encode never exceeds NUM_REQS-1.
- Invariants, checked by assertions:
  - $onehot0(o__grant_onehot).
  - o__grant_valid == |o__grant_onehot.
  - When valid, o__grant_onehot == 1<<o__grant_encode.
- Reset asserted mid-grant: the grant drops immediately, and priority restarts at requester 0 after release.
- Fairness: with all requests continuously asserted and ack every cycle, each requester is granted exactly once in every NUM_REQS consecutive grants.
- Implementation: two-stage priority search (masked request vector ≥ ptr, falling back to the unmasked vector) or an equivalent rotate. No combinational path from i__request to any output.

Test Plan:
- Reset, then i__request=11'h000 for 5 cycles, then pulse rst_n low mid-cycle -> all outputs 0, ptr stays 0, reset effect visible without a clock edge.
- i__request=11'b00000100100 from IDLE, ack on 3rd cycle -> grant onehot 11'b00000000100, encode 2, held 3 cycles; next cycle grant 11'b00000100000, encode 5, no bubble.
- All 11 requests high, ack every cycle for 22 grants -> encode sequence 0,1,…,10,0,…,10; valid constantly 1 after the first cycle.
- Grant on requester 10 (only request 11'b10000000000), ack, then i__request=11'b00000000001 -> ptr wraps to 0; next grant encode 0.
- Granted request deasserted before ack while requester 3 is asserting -> grant on the original index held unchanged until ack; then encode 3.
- Ack pulses while IDLE with no requests, then single request bit 7 -> no output change during the acks; grant encode 7 one cycle after the request.
